// File: rtl/pattern_detector_pkg.sv
// Shared defaults and state encoding for the serial pattern detector.
package pattern_detector_pkg;

  localparam int         PAT_W_DEF           = 4;
  localparam logic [3:0] DEFAULT_PAT_DEF     = 4'b1001;
  localparam int         CNT_W_DEF           = 8;
  localparam bit         OVERLAP_DEFAULT_DEF = 1'b1;

  typedef enum logic [1:0] {
    FILLING = 2'd0,
    ARMED   = 2'd1,
    MATCH   = 2'd2
  } state_t;

endpackage

// File: rtl/pattern_detector_moore_seq_history.sv
// Serial history shift register, fill counter and pattern compare.
// hit is the combinational match condition for the bit being accepted this cycle.
module seq_history
  import pattern_detector_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit,
  output logic             full_next
);

  localparam int FW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] history;
  logic [PAT_W-1:0] history_next;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_next;
  logic             accept;

  always_comb begin
    accept       = in_valid && !clear;
    history_next = {history[PAT_W-2:0], in};
    fill_next    = (fill == FW'(PAT_W)) ? fill : fill + FW'(1);
    full_next    = (fill_next == FW'(PAT_W));
    // Fill gate keeps an all-zero pattern from matching the cleared history.
    hit          = accept && full_next && (history_next == pattern);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      history <= '0;
      fill    <= '0;
    end else if (accept) begin
      history <= history_next;
      fill    <= (hit && !overlap) ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/pattern_detector_moore.sv
// Moore serial pattern detector: registered one-cycle match flag and a
// saturating match counter, with runtime-loadable pattern and overlap mode.
module pattern_detector_moore
  import pattern_detector_pkg::*;
#(
  parameter int               PAT_W           = PAT_W_DEF,
  parameter logic [PAT_W-1:0] DEFAULT_PAT     = DEFAULT_PAT_DEF,
  parameter bit               OVERLAP_DEFAULT = OVERLAP_DEFAULT_DEF,
  parameter int               CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_count
);

  logic [PAT_W-1:0] pattern;
  logic             overlap;
  logic             hit;
  logic             full_next;
  state_t           state;

  seq_history #(.PAT_W(PAT_W)) u_hist (
    .clk       (clk),
    .reset     (reset),
    .clear     (cfg_load),
    .in        (in),
    .in_valid  (in_valid),
    .overlap   (overlap),
    .pattern   (pattern),
    .hit       (hit),
    .full_next (full_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern <= DEFAULT_PAT;
      overlap <= OVERLAP_DEFAULT;
      state   <= FILLING;
      out     <= 1'b0;
    end else if (cfg_load) begin
      pattern <= cfg_pattern;
      overlap <= cfg_overlap;
      state   <= FILLING;
      out     <= 1'b0;
    end else if (in_valid) begin
      if (hit) begin
        state <= MATCH;
        out   <= 1'b1;
      end else begin
        state <= full_next ? ARMED : FILLING;
        out   <= 1'b0;
      end
    end else begin
      out <= 1'b0;
      // Non-overlap match already cleared the fill, so idle falls back to FILLING.
      if (state == MATCH) state <= overlap ? ARMED : FILLING;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      match_count <= '0;
    end else if (hit && (match_count != {CNT_W{1'b1}})) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pattern_detector_moore.sv
// Scoreboard bench for pattern_detector_moore: default instance plus a
// CNT_W=2 instance sharing the same stimulus for the saturation scenario.
module tb_pattern_detector_moore;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       d_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [3:0] cfg_pattern = 4'b0000;
  logic       cfg_overlap = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       out_a;
  logic [7:0] count_a;
  logic       out_b;
  logic [1:0] count_b;

  int total = 0;
  int bad = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  pattern_detector_moore dut_a (
    .clk(clk), .reset(reset), .in(d_in), .in_valid(in_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .out(out_a), .match_count(count_a)
  );

  pattern_detector_moore #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in(d_in), .in_valid(in_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .out(out_b), .match_count(count_b)
  );

  // Apply inputs now (we sit 1 time unit after an edge), advance one edge.
  task automatic drive(input logic v, input logic b);
    in_valid = v;
    d_in     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Push expectations for a serial run, drive it, pop and compare per bit.
  task automatic run_bits(input string name, input int n, input logic [15:0] bits,
                          input logic [15:0] exp_out);
    logic e;
    for (int i = n - 1; i >= 0; i--) begin
      exp_q.push_back(exp_out[i]);
      drive(1'b1, bits[i]);
      e = exp_q.pop_front();
      total++;
      if (out_a !== e) begin
        bad++;
        $display("FAIL %s bit%0d: out=%b expected %b", name, n - 1 - i, out_a, e);
      end
    end
  endtask

  task automatic test_reset;
    do_reset(5);
    total++;
    if (out_a !== 1'b0 || count_a !== 8'd0) begin
      bad++;
      $display("FAIL reset_a: out=%b count=%0d expected 0/0", out_a, count_a);
    end
    total++;
    if (out_b !== 1'b0 || count_b !== 2'd0) begin
      bad++;
      $display("FAIL reset_b: out=%b count=%0d expected 0/0", out_b, count_b);
    end
  endtask

  task automatic test_basic;
    run_bits("basic", 4, 16'b1001, 16'b0001);
    exp_q.push_back(1'b0);
    drive(1'b0, 1'b0);
    total++;
    if (out_a !== exp_q.pop_front()) begin
      bad++;
      $display("FAIL basic_pulse_width: out=%b expected 0", out_a);
    end
    total++;
    if (count_a !== 8'd1) begin
      bad++;
      $display("FAIL basic_count: count=%0d expected 1", count_a);
    end
  endtask

  task automatic test_overlap;
    do_reset(1);
    run_bits("overlap1", 7, 16'b1001001, 16'b0001001);
    total++;
    if (count_a !== 8'd2) begin
      bad++;
      $display("FAIL overlap1_count: count=%0d expected 2", count_a);
    end
    do_reset(1);
    cfg_load = 1'b1; cfg_pattern = 4'b1001; cfg_overlap = 1'b0;
    drive(1'b0, 1'b0);
    cfg_load = 1'b0;
    run_bits("overlap0", 7, 16'b1001001, 16'b0001000);
    total++;
    if (count_a !== 8'd1) begin
      bad++;
      $display("FAIL overlap0_count: count=%0d expected 1", count_a);
    end
  endtask

  task automatic test_gap;
    do_reset(1);
    run_bits("gap_head", 2, 16'b10, 16'b00);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(1'b0);
      drive(1'b0, 1'b1);
      total++;
      if (out_a !== exp_q.pop_front()) begin
        bad++;
        $display("FAIL gap_idle%0d: out=%b expected 0", i, out_a);
      end
    end
    run_bits("gap_tail", 2, 16'b01, 16'b01);
  endtask

  task automatic test_cfg;
    do_reset(1);
    run_bits("cfg_pre", 7, 16'b1001100, 16'b0001000);
    // cfg_load coincident with an accepted bit: the bit must be discarded.
    cfg_load = 1'b1; cfg_pattern = 4'b0110; cfg_overlap = 1'b1;
    exp_q.push_back(1'b0);
    drive(1'b1, 1'b0);
    cfg_load = 1'b0;
    total++;
    if (out_a !== exp_q.pop_front() || count_a !== 8'd1) begin
      bad++;
      $display("FAIL cfg_load: out=%b count=%0d expected 0/1", out_a, count_a);
    end
    run_bits("cfg_new", 5, 16'b10110, 16'b00001);
    total++;
    if (count_a !== 8'd2) begin
      bad++;
      $display("FAIL cfg_count: count=%0d expected 2", count_a);
    end
  endtask

  task automatic test_zero_pattern;
    do_reset(1);
    cfg_load = 1'b1; cfg_pattern = 4'b0000; cfg_overlap = 1'b1;
    drive(1'b0, 1'b0);
    cfg_load = 1'b0;
    run_bits("zero_pat", 5, 16'b00000, 16'b00011);
  endtask

  task automatic test_saturate;
    do_reset(1);
    run_bits("sat", 16, 16'b1001001001001001, 16'b0001001001001001);
    total++;
    if (count_b !== 2'd3) begin
      bad++;
      $display("FAIL sat_count_b: count=%0d expected 3", count_b);
    end
    total++;
    if (count_a !== 8'd5) begin
      bad++;
      $display("FAIL sat_count_a: count=%0d expected 5", count_a);
    end
    run_bits("sat_pre_clr", 2, 16'b00, 16'b00);
    cnt_clr = 1'b1;
    run_bits("sat_clr_match", 1, 16'b1, 16'b1);
    cnt_clr = 1'b0;
    total++;
    if (count_b !== 2'd0 || count_a !== 8'd0 || out_b !== 1'b1) begin
      bad++;
      $display("FAIL clr_vs_match: count_a=%0d count_b=%0d out_b=%b expected 0/0/1",
               count_a, count_b, out_b);
    end
  endtask

  task automatic test_back_to_back_reset;
    do_reset(1);
    run_bits("mid_pre", 3, 16'b100, 16'b000);
    // Reset must beat cfg_load, cnt_clr and a valid bit on the same edge.
    reset = 1'b1; cfg_load = 1'b1; cfg_pattern = 4'b0001; cfg_overlap = 1'b0; cnt_clr = 1'b1;
    drive(1'b1, 1'b1);
    reset = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    total++;
    if (out_a !== 1'b0 || count_a !== 8'd0) begin
      bad++;
      $display("FAIL mid_reset: out=%b count=%0d expected 0/0", out_a, count_a);
    end
    run_bits("mid_post", 5, 16'b11001, 16'b00001);
    total++;
    if (count_a !== 8'd1) begin
      bad++;
      $display("FAIL mid_count: count=%0d expected 1", count_a);
    end
  endtask

  initial begin
    #1;
    test_reset;
    test_basic;
    test_overlap;
    test_gap;
    test_cfg;
    test_zero_pattern;
    test_saturate;
    test_back_to_back_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
